// File: rtl/watch_pkg.sv
// watch_pkg: shared state encodings and default timing constants for the watch front panel
package watch_pkg;
  typedef enum logic [1:0] {ST_TIMER = 2'd0, ST_SET_MIN = 2'd1, ST_SET_HOUR = 2'd2} state_t;
  typedef enum logic [1:0] {RP_IDLE = 2'd0, RP_DELAY = 2'd1, RP_RATE = 2'd2} rep_t;
  localparam int CNT_W = 26;
  localparam int DEBOUNCE_CNT = 1048576;
  localparam int REPEAT_DELAY = 26214400;
  localparam int REPEAT_RATE = 5242880;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, stability counter and one-cycle press strobe for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CNT = watch_pkg::DEBOUNCE_CNT,
  parameter int CNT_W = watch_pkg::CNT_W
) (
  input  logic reset,
  input  logic clock,
  input  logic key_n,
  output logic level,
  output logic press
);
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sync <= 2'b11;
      level <= 1'b1;
      press <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
        level <= sync[1];
        press <= ~sync[1];
        cnt <= '0;
      end else cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/watch_mode_ctrl.sv
// watch_mode_ctrl: button debounce, TIMER/SET_MIN/SET_HOUR mode FSM and INC auto-repeat for the watch register
module watch_mode_ctrl #(
  parameter int DEBOUNCE_CNT = watch_pkg::DEBOUNCE_CNT,
  parameter int REPEAT_DELAY = watch_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE = watch_pkg::REPEAT_RATE,
  parameter int CNT_W = watch_pkg::CNT_W
) (
  input  logic reset,
  input  logic clock,
  input  logic key_mode_n,
  input  logic key_inc_n,
  output logic mode,
  output logic minute_set,
  output logic hour_set,
  output logic edit_min,
  output logic edit_hour
);
  import watch_pkg::*;
  state_t state, nxt;
  rep_t phase;
  logic [CNT_W-1:0] rcnt;
  logic mode_press, inc_press, inc_level, rep_end, fire;
  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_mode (
    .reset(reset), .clock(clock), .key_n(key_mode_n), .level(), .press(mode_press)
  );
  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT), .CNT_W(CNT_W)) u_inc (
    .reset(reset), .clock(clock), .key_n(key_inc_n), .level(inc_level), .press(inc_press)
  );
  always_comb nxt = state == ST_TIMER ? ST_SET_MIN : state == ST_SET_MIN ? ST_SET_HOUR : ST_TIMER;
  always_comb rep_end = rcnt == (phase == RP_DELAY ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_RATE - 1));
  always_comb fire = inc_press || (phase != RP_IDLE && !inc_level && rep_end);
  // a mode press always wins over INC and kills any repeat in progress
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_TIMER;
      mode <= 1'b1;
      edit_min <= 1'b0;
      edit_hour <= 1'b0;
      minute_set <= 1'b0;
      hour_set <= 1'b0;
      phase <= RP_IDLE;
      rcnt <= '0;
    end else begin
      minute_set <= 1'b0;
      hour_set <= 1'b0;
      if (mode_press) begin
        state <= nxt;
        mode <= nxt == ST_TIMER;
        edit_min <= nxt == ST_SET_MIN;
        edit_hour <= nxt == ST_SET_HOUR;
        phase <= RP_IDLE;
        rcnt <= '0;
      end else if (state != ST_TIMER) begin
        minute_set <= fire && state == ST_SET_MIN;
        hour_set <= fire && state == ST_SET_HOUR;
        phase <= inc_press ? RP_DELAY : (inc_level || phase == RP_IDLE) ? RP_IDLE : rep_end ? RP_RATE : phase;
        rcnt <= (inc_press || inc_level || phase == RP_IDLE || rep_end) ? '0 : rcnt + CNT_W'(1);
      end
    end
endmodule
